// File: rtl/obi_initiator.sv
// OBI bus initiator: turns word-burst commands into OBI read/write requests,
// streaming write data in and read data out through a small FWFT FIFO.
module obi_initiator #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RD_FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_we,
  input  logic [DATA_WIDTH/8-1:0] cmd_be,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  output logic                    data_req,
  output logic [ADDR_WIDTH-1:0]   data_addr,
  output logic                    data_we,
  output logic [DATA_WIDTH/8-1:0] data_be,
  output logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic                    data_gnt,
  input  logic                    data_rvalid,
  input  logic                    data_err,
  input  logic [DATA_WIDTH-1:0]   data_rdata
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam int unsigned OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW   = $clog2(RD_FIFO_DEPTH + 1);
  localparam int unsigned PW   = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;

  localparam logic [OW-1:0]         MAX_O    = OW'(MAX_OUTSTANDING);
  localparam logic [CW:0]           DEPTH_C  = (CW + 1)'(RD_FIFO_DEPTH);
  localparam logic [PW-1:0]         LAST_PTR = PW'(RD_FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(BE_W);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    rem_q;
  logic                    we_q;
  logic [BE_W-1:0]         be_q;
  logic [OW-1:0]           outst_q, outst_nxt;
  logic                    err_acc_q, err_nxt;
  logic                    done_q, err_q;

  logic [DATA_WIDTH-1:0]   mem [RD_FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           fifo_cnt_q, fifo_cnt_nxt;

  logic                    gnt, resp_cnt, stray, push, pop, drain_ok;
  logic [CW:0]             inflight;

  // Reads may only be issued when every in-flight beat already has a FIFO slot.
  assign inflight = (CW + 1)'(fifo_cnt_q) + (CW + 1)'(outst_q);
  assign data_req = (state_q == ISSUE) && (outst_q < MAX_O) &&
                    (we_q ? wr_valid : (inflight < DEPTH_C));

  assign gnt      = data_req & data_gnt;
  assign resp_cnt = data_rvalid && (state_q != IDLE) && (outst_q != '0);
  assign stray    = data_rvalid && (state_q != IDLE) && (outst_q == '0);
  assign push     = resp_cnt & ~we_q;
  assign pop      = rd_valid & rd_ready;

  always_comb begin
    outst_nxt = outst_q;
    if (gnt && !resp_cnt)      outst_nxt = outst_q + OW'(1);
    else if (!gnt && resp_cnt) outst_nxt = outst_q - OW'(1);

    fifo_cnt_nxt = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_nxt = fifo_cnt_q + CW'(1);
    else if (!push && pop) fifo_cnt_nxt = fifo_cnt_q - CW'(1);

    err_nxt  = err_acc_q | (resp_cnt & data_err) | stray;
    drain_ok = (outst_nxt == '0) && (we_q || (fifo_cnt_nxt == '0));
  end

  // Completion is judged on post-edge counts so done lands one cycle after the
  // final beat leaves; the FSM then spends the done cycle in DRAIN before IDLE.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      outst_q   <= '0;
      err_acc_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      outst_q   <= outst_nxt;
      err_acc_q <= err_nxt;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            rem_q     <= cmd_len;
            we_q      <= cmd_we;
            be_q      <= cmd_be;
            err_acc_q <= 1'b0;
            state_q   <= (cmd_len != '0) ? ISSUE : DRAIN;
          end
        end
        ISSUE: begin
          if (gnt) begin
            addr_q <= addr_q + STRIDE;
            rem_q  <= rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (done_q) begin
            state_q <= IDLE;
          end else if (drain_ok) begin
            done_q <= 1'b1;
            err_q  <= err_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_nxt;
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_rdata;
  end

  assign rd_valid   = (fifo_cnt_q != '0);
  assign rd_data    = mem[rd_ptr_q];
  assign wr_ready   = gnt & we_q;
  assign data_addr  = addr_q;
  assign data_we    = we_q;
  assign data_be    = be_q;
  assign data_wdata = (data_req && we_q) ? wr_data : '0;
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/obi_initiator.md
OBI_INITIATOR -- requirements
Module: obi_initiator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the command word count.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered requests; range 1..4.
REQ-005 SHALL have parameter RD_FIFO_DEPTH, default 4, read-data FIFO entries; must be >= MAX_OUTSTANDING.
REQ-006 SHALL have ports, one per line:
  clk  in  1  clock, all logic on rising edge
  rst_ni  in  1  reset, asynchronous, active-low
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_addr  in  ADDR_WIDTH  start byte address, word aligned
  cmd_len  in  LEN_WIDTH  number of words
  cmd_we  in  1  1 = write burst, 0 = read burst
  cmd_be  in  DATA_WIDTH/8  byte enables for every beat
  wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_WIDTH  write-data stream
  rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_WIDTH  read-data stream
  done  out  1  one-cycle pulse, command complete
  err  out  1  valid with done; any beat returned data_err
  busy  out  1  command in progress
  data_req, data_addr, data_we, data_be, data_wdata  out  1, ADDR_WIDTH, 1, DATA_WIDTH/8, DATA_WIDTH  memory request
  data_gnt, data_rvalid, data_err, data_rdata  in  1, 1, 1, DATA_WIDTH  memory response

Function
REQ-007 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-008 IDLE: cmd_ready=1; on cmd_valid latch addr/len/we/be, clear err accumulator; go to ISSUE if len!=0, else DRAIN.
REQ-009 ISSUE: data_req asserted when outstanding < MAX_OUTSTANDING and (write: wr_valid) or (read: fifo_count + outstanding < RD_FIFO_DEPTH).
REQ-010 Once data_req is high, data_req/addr/we/be/wdata SHALL hold stable until the cycle data_gnt=1.
REQ-011 On a write, wr_ready SHALL pulse in the grant cycle only (data consumed on grant).
REQ-012 On grant: address += DATA_WIDTH/8 (modulo 2^ADDR_WIDTH, wraps silently), remaining -= 1, outstanding += 1; remaining reaching 0 -> DRAIN.
REQ-013 Grant and data_rvalid in the same cycle SHALL leave outstanding unchanged.
REQ-014 Earliest response is the cycle after grant; back-to-back grants SHALL sustain one beat per cycle.
REQ-015 On data_rvalid: outstanding -= 1; err accumulator |= data_err; on read, data_rdata pushed to FIFO (write responses not pushed).
REQ-016 data_rvalid with outstanding==0 SHALL be ignored for counting/FIFO and set the err accumulator.
REQ-017 DRAIN: exit to IDLE when outstanding==0 and (write, or read FIFO empty); done=1 and err=accumulator that cycle.
REQ-018 Read FIFO: rd_valid = not empty, pop on rd_valid & rd_ready, first-word-fall-through, push and pop same cycle legal when non-empty; no overflow possible by REQ-009.
REQ-019 busy SHALL equal state != IDLE.
REQ-020 cmd_ready SHALL be 0 outside IDLE; a new command is accepted the cycle after done at earliest.

Reset
REQ-021 rst_ni low SHALL asynchronously force IDLE, outstanding=0, FIFO empty, err accumulator 0.
REQ-022 Reset values: cmd_ready=1 once released, data_req=0, wr_ready=0, rd_valid=0, done=0, err=0, busy=0, data_addr/be/wdata=0, data_we=0.
REQ-023 Reset mid-burst SHALL drop data_req immediately; responses arriving after release with outstanding==0 follow REQ-016 only if busy, else ignored.

Verification
REQ-024 Read len=4 at 0x100, responder gnt=req, rvalid next cycle, rd_ready=1 -> addrs 0x100,0x104,0x108,0x10C on 4 consecutive cycles; 4 rd beats in order; done 1 cycle after last beat, err=0.
REQ-025 Write len=3 at 0x200, be=4'b0011, wr_valid toggling 1,0,1,1 -> requests only when wr_valid, wdata matches stream order, be=0011 every beat, done with err=0.
REQ-026 Read len=8, rd_ready=0 for 10 cycles -> exactly RD_FIFO_DEPTH requests granted then data_req=0; resumes when rd_ready=1; all 8 words delivered.
REQ-027 Responder holds gnt=0 for 3 cycles -> data_req/addr/be/wdata stable all 3 cycles; one grant counted.
REQ-028 Read len=2, data_err=1 on beat 1 -> err=1 with done; len=0 command -> done 2 cycles after accept, no data_req.
REQ-029 Start address 0xFFFF_FFFC, len=2 -> second address 0x0000_0000; rst_ni low mid-burst -> all outputs at REQ-022 values same cycle.
